// File: rtl/io_request_arbiter.sv
// Round-robin arbiter sharing one non-cached I/O bus between NUM_REQUESTERS request queues.
// Optional feature macro: IO_ARB_PERF_EN adds the perf_io_grant / perf_io_contend outputs.

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_arb_pkg;
    typedef logic [31:0] scalar_t;
    typedef logic [3:0]  core_id_t;
    typedef logic [3:0]  thread_idx_t;

    typedef struct packed {
        logic        store;
        thread_idx_t thread_idx;
        scalar_t     address;
        scalar_t     value;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t    core;
        thread_idx_t thread_idx;
        scalar_t     read_value;
    } iorsp_packet_t;
endpackage

module io_request_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = `NUM_CORES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] ioreq_valid,
    input  ioreq_packet_t             ioreq_packet [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] ioreq_ack,
    output logic                      io_bus_write_en,
    output logic                      io_bus_read_en,
    output scalar_t                   io_bus_address,
    output scalar_t                   io_bus_write_data,
    input  scalar_t                   io_bus_read_data,
    output logic                      iorsp_valid,
    output iorsp_packet_t             iorsp_packet
`ifdef IO_ARB_PERF_EN
    ,
    output logic                      perf_io_grant,
    output logic                      perf_io_contend
`endif
);

    core_id_t      rr_ptr;
    core_id_t      rr_next;
    core_id_t      grant_idx;
    logic          any_grant;
    ioreq_packet_t sel_pkt;

    logic          s1_valid;
    logic          s1_store;
    core_id_t      s1_core;
    thread_idx_t   s1_thread;

    logic          s2_valid;
    logic          s2_store;
    core_id_t      s2_core;
    thread_idx_t   s2_thread;

    // Two passes: indices at/after the pointer first, then the wrapped-around low indices.
    always_comb begin
        ioreq_ack = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sel_pkt   = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!any_grant && (i >= int'(rr_ptr)) && ioreq_valid[i]) begin
                any_grant    = 1'b1;
                grant_idx    = core_id_t'(i);
                ioreq_ack[i] = 1'b1;
                sel_pkt      = ioreq_packet[i];
            end
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!any_grant && (i < int'(rr_ptr)) && ioreq_valid[i]) begin
                any_grant    = 1'b1;
                grant_idx    = core_id_t'(i);
                ioreq_ack[i] = 1'b1;
                sel_pkt      = ioreq_packet[i];
            end
        end
    end

    always_comb begin
        if (grant_idx == core_id_t'(NUM_REQUESTERS - 1))
            rr_next = '0;
        else
            rr_next = grant_idx + core_id_t'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr            <= '0;
            io_bus_write_en   <= 1'b0;
            io_bus_read_en    <= 1'b0;
            io_bus_address    <= '0;
            io_bus_write_data <= '0;
            s1_valid          <= 1'b0;
            s1_store          <= 1'b0;
            s1_core           <= '0;
            s1_thread         <= '0;
            s2_valid          <= 1'b0;
            s2_store          <= 1'b0;
            s2_core           <= '0;
            s2_thread         <= '0;
            iorsp_valid       <= 1'b0;
            iorsp_packet      <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr            <= rr_next;
                io_bus_address    <= sel_pkt.address;
                io_bus_write_data <= sel_pkt.value;
            end
            io_bus_write_en <= any_grant && sel_pkt.store;
            io_bus_read_en  <= any_grant && !sel_pkt.store;

            s1_valid  <= any_grant;
            s1_store  <= sel_pkt.store;
            s1_core   <= grant_idx;
            s1_thread <= sel_pkt.thread_idx;

            s2_valid  <= s1_valid;
            s2_store  <= s1_store;
            s2_core   <= s1_core;
            s2_thread <= s1_thread;

            // Load data is on the bus during the cycle after read_en, i.e. while the tag sits in s2.
            iorsp_valid <= s2_valid;
            if (s2_valid) begin
                iorsp_packet.core       <= s2_core;
                iorsp_packet.thread_idx <= s2_thread;
                iorsp_packet.read_value <= s2_store ? '0 : io_bus_read_data;
            end
        end
    end

`ifdef IO_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_io_grant   <= 1'b0;
            perf_io_contend <= 1'b0;
        end else begin
            perf_io_grant   <= any_grant;
            perf_io_contend <= ($countones(ioreq_valid) > 1);
        end
    end
`endif

endmodule
